// File: rtl/lenet_ctrl_pkg.sv
// Shared types and constants for the LeNet batch controller.
package lenet_ctrl_pkg;

  localparam int GRAPH_W = 5;

  localparam logic [1:0] RIGHT_NONE = 2'b00;
  localparam logic [1:0] RIGHT_OK   = 2'b01;
  localparam logic [1:0] RIGHT_BAD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } lbc_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, hold-time debounce, one-cycle press
// pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          s1_q, s2_q, lvl_q, press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      press_q <= 1'b0;
      // Counter tracks consecutive samples disagreeing with the accepted level.
      if (s2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        cnt_q   <= '0;
        lvl_q   <= s2_q;
        press_q <= s2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/lenet_batch_ctrl.sv
// Start/sweep sequencer in front of lenet_top; tallies verdicts per run.
// Optional inference watchdog enabled by defining LBC_WATCHDOG_EN.
module lenet_batch_ctrl
  import lenet_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES     = 1000000,
  parameter int NUM_GRAPHS     = 32,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               sweep_en,
  input  logic [GRAPH_W-1:0] graph_sel,
  input  logic               lenet_finish,
  input  logic [1:0]         right,
  output logic               lenet_start,
  output logic [GRAPH_W-1:0] graph,
  output logic               busy,
  output logic               batch_done,
  output logic [5:0]         correct_cnt,
  output logic [5:0]         total_cnt,
  output logic               timeout_err
);

  logic press;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_start),
    .press_o (press)
  );

  lbc_state_t         state_q, state_d;
  logic [GRAPH_W-1:0] graph_q, graph_d;
  logic               mode_q, mode_d;
  logic [5:0]         corr_q, corr_d, tot_q, tot_d;
  logic               to_q, to_d;
  logic               wd_hit;

`ifdef LBC_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != ST_WAIT) wd_q <= '0;
    else                           wd_q <= wd_q + 1'b1;
  end

  assign wd_hit = (state_q == ST_WAIT) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_hit         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    graph_d = graph_q;
    mode_d  = mode_q;
    corr_d  = corr_q;
    tot_d   = tot_q;
    to_d    = to_q;
    unique case (state_q)
      // DONE restarts exactly like IDLE so a press there begins a fresh run.
      ST_IDLE, ST_DONE: begin
        if (press) begin
          corr_d  = '0;
          tot_d   = '0;
          to_d    = 1'b0;
          mode_d  = sweep_en;
          graph_d = sweep_en ? '0 : graph_sel;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (lenet_finish) begin
          tot_d   = tot_q + 6'd1;
          if (right == RIGHT_OK) corr_d = corr_q + 6'd1;
          state_d = ST_NEXT;
        end else if (wd_hit) begin
          to_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_NEXT: begin
        if (!mode_q || graph_q == GRAPH_W'(NUM_GRAPHS - 1)) begin
          state_d = ST_DONE;
        end else begin
          graph_d = graph_q + 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      graph_q <= '0;
      mode_q  <= 1'b0;
      corr_q  <= '0;
      tot_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      graph_q <= graph_d;
      mode_q  <= mode_d;
      corr_q  <= corr_d;
      tot_q   <= tot_d;
      to_q    <= to_d;
    end
  end

  assign lenet_start = (state_q == ST_LAUNCH);
  assign busy        = (state_q != ST_IDLE);
  assign batch_done  = (state_q == ST_DONE);
  assign graph       = graph_q;
  assign correct_cnt = corr_q;
  assign total_cnt   = tot_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_lenet_batch_ctrl.sv
// Self-checking bench for lenet_batch_ctrl: cycle model compared every cycle,
// a lenet_top responder, and literal checkpoints per scenario.
module tb_lenet_batch_ctrl;

  localparam int DEB = 4;
  localparam int NG  = 4;
  localparam int TO  = 50;

  localparam int M_IDLE = 0, M_LAUNCH = 1, M_WAIT = 2, M_NEXT = 3, M_DONE = 4;

  logic       clk = 1'b0;
  logic       rst, btn_start, sweep_en, lenet_finish;
  logic [4:0] graph_sel;
  logic [1:0] right;
  logic       lenet_start, busy, batch_done, timeout_err;
  logic [4:0] graph;
  logic [5:0] correct_cnt, total_cnt;

  lenet_batch_ctrl #(.DEB_CYCLES(DEB), .NUM_GRAPHS(NG), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .sweep_en(sweep_en),
    .graph_sel(graph_sel), .lenet_finish(lenet_finish), .right(right),
    .lenet_start(lenet_start), .graph(graph), .busy(busy),
    .batch_done(batch_done), .correct_cnt(correct_cnt),
    .total_cnt(total_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   mst = M_IDLE, mgraph = 0, mcorr = 0, mtot = 0, mwd = 0;
  bit   mmode = 0, mto = 0, mlvl = 0, mpress = 0, m_pr, m_stable;
  logic hist [0:DEB];

  always @(posedge clk) begin
    if (rst) begin
      mst = M_IDLE; mgraph = 0; mmode = 0; mcorr = 0; mtot = 0; mto = 0; mwd = 0;
      mlvl = 0; mpress = 0;
      for (int i = 0; i <= DEB; i++) hist[i] = 1'b0;
    end else begin
      // Accepted level flips once the last DEB synchronized samples agree on the other value.
      m_pr = mpress;
      m_stable = 1;
      for (int i = 1; i <= DEB; i++) if (hist[i] !== hist[1]) m_stable = 0;
      if (m_stable && hist[1] != mlvl) begin mlvl = hist[1]; mpress = hist[1]; end
      else mpress = 0;
      for (int i = DEB; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = btn_start;
      case (mst)
        M_IDLE, M_DONE:
          if (m_pr) begin
            mcorr = 0; mtot = 0; mto = 0; mmode = sweep_en;
            mgraph = sweep_en ? 0 : int'(graph_sel);
            mst = M_LAUNCH;
          end
        M_LAUNCH: begin mwd = 0; mst = M_WAIT; end
        M_WAIT:
          if (lenet_finish) begin
            mtot++;
            if (right == 2'b01) mcorr++;
            mst = M_NEXT;
          end else begin
`ifdef LBC_WATCHDOG_EN
            mwd++;
            if (mwd == TO) begin mto = 1; mst = M_DONE; end
`endif
          end
        M_NEXT:
          if (!mmode || mgraph == NG - 1) mst = M_DONE;
          else begin mgraph++; mst = M_LAUNCH; end
        default: mst = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("lenet_start", 32'(lenet_start), 32'(mst == M_LAUNCH));
      chk("graph",       32'(graph),       32'(mgraph));
      chk("busy",        32'(busy),        32'(mst != M_IDLE));
      chk("batch_done",  32'(batch_done),  32'(mst == M_DONE));
      chk("correct_cnt", 32'(correct_cnt), 32'(mcorr));
      chk("total_cnt",   32'(total_cnt),   32'(mtot));
      chk("timeout_err", 32'(timeout_err), 32'(mto));
    end
  end

  // ---------------- lenet_top responder ----------------
  logic [1:0] codes [0:255];
  int wr_idx = 0, rd_idx = 0;
  int resp_delay = 10, drop_graph = -1;
  int ncyc = 0, fin_cnt = 0, fin_at = -1, starts = 0, lat_n = 0, lat_bad = 0;
  int lat_t0 = 1 << 30;
  int sgraph [0:1023];

  always @(negedge clk) begin
    ncyc++;
    lenet_finish = 1'b0;
    right = 2'($urandom);
    if (fin_cnt > 0) begin
      fin_cnt--;
      if (fin_cnt == 0) begin
        lenet_finish = 1'b1;
        right = (rd_idx < wr_idx) ? codes[rd_idx % 256] : 2'b00;
        rd_idx++;
        fin_at = ncyc;
      end
    end
    if (lenet_start) begin
      sgraph[starts % 1024] = int'(graph);
      starts++;
      if (fin_at > lat_t0) begin
        lat_n++;
        if (ncyc - fin_at != 2) lat_bad++;
      end
      if (int'(graph) != drop_graph) fin_cnt = resp_delay;
    end
  end

  task automatic push_code(input logic [1:0] c);
    codes[wr_idx % 256] = c;
    wr_idx++;
  endtask

  task automatic press();
    btn_start = 1'b1;
    repeat (DEB + 4) @(negedge clk);
    btn_start = 1'b0;
    repeat (DEB + 4) @(negedge clk);
  endtask

  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 600 && batch_done !== 1'b1; k++) @(negedge clk);
    chk(nm, 32'(batch_done), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int s0;

  initial begin
    rst = 1'b1; btn_start = 1'b0; sweep_en = 1'b0; graph_sel = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_lenet_start", 32'(lenet_start), 0);
    chk("rst_busy",        32'(busy), 0);
    chk("rst_batch_done",  32'(batch_done), 0);
    chk("rst_graph",       32'(graph), 0);
    chk("rst_total",       32'(total_cnt), 0);
    chk("rst_correct",     32'(correct_cnt), 0);
    chk("rst_timeout",     32'(timeout_err), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Bounce rejection
    sweep_en = 1'b1;
    for (int i = 0; i < 4; i++) push_code(2'b01);
    s0 = starts;
    for (int i = 0; i < 10; i++) begin
      btn_start = ~btn_start;
      repeat (2) @(negedge clk);
    end
    chk("bounce_no_start", 32'(starts - s0), 0);
    btn_start = 1'b1;
    repeat (10) @(negedge clk);
    chk("bounce_one_start", 32'(starts - s0), 1);
    chk("bounce_graph0", 32'(sgraph[s0 % 1024]), 0);
    btn_start = 1'b0;
    wait_done("bounce_done");
    chk("bounce_total", 32'(total_cnt), 4);
    chk("bounce_correct", 32'(correct_cnt), 4);

    // Single run on graph 7
    sweep_en = 1'b0; graph_sel = 5'd7; resp_delay = 10;
    push_code(2'b01);
    press();
    wait_done("single_done");
    chk("single_graph", 32'(graph), 7);
    chk("single_total", 32'(total_cnt), 1);
    chk("single_correct", 32'(correct_cnt), 1);

    // Full sweep with mixed verdicts
    sweep_en = 1'b1;
    push_code(2'b01); push_code(2'b10); push_code(2'b01); push_code(2'b00);
    s0 = starts; lat_t0 = ncyc;
    begin
      int ln0, lb0;
      ln0 = lat_n; lb0 = lat_bad;
      press();
      wait_done("sweep_done");
      lat_t0 = 1 << 30;
      chk("sweep_starts", 32'(starts - s0), 4);
      for (int i = 0; i < 4; i++) chk("sweep_graph_seq", 32'(sgraph[(s0 + i) % 1024]), 32'(i));
      chk("sweep_lat_count", 32'(lat_n - ln0), 3);
      chk("sweep_lat_errs", 32'(lat_bad - lb0), 0);
    end
    chk("sweep_total", 32'(total_cnt), 4);
    chk("sweep_correct", 32'(correct_cnt), 2);

    // Restart from DONE; a press during WAIT is dropped
    sweep_en = 1'b0; graph_sel = 5'd2; resp_delay = 40;
    push_code(2'b01);
    s0 = starts;
    press();
    chk("restart_cleared_total", 32'(total_cnt), 0);
    chk("restart_busy", 32'(busy), 1);
    press();
    wait_done("restart_done");
    chk("restart_starts", 32'(starts - s0), 1);
    chk("restart_graph", 32'(sgraph[s0 % 1024]), 2);
    chk("restart_total", 32'(total_cnt), 1);

    // Reset during WAIT of graph 2
    sweep_en = 1'b1; resp_delay = 10;
    for (int i = 0; i < 4; i++) push_code(2'b01);
    s0 = starts;
    press();
    for (int k = 0; k < 200 && starts - s0 < 3; k++) @(negedge clk);
    chk("midrst_reached_g2", 32'(starts - s0), 3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_start", 32'(lenet_start), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_graph", 32'(graph), 0);
    chk("midrst_total", 32'(total_cnt), 0);
    chk("midrst_correct", 32'(correct_cnt), 0);
    repeat (15) @(negedge clk);
    chk("midrst_finish_ignored", 32'(total_cnt), 0);
    chk("midrst_still_idle", 32'(busy), 0);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      sweep_en = 1'($urandom);
      graph_sel = 5'($urandom);
      resp_delay = $urandom_range(1, 8);
      for (int i = 0; i < 4; i++) push_code(2'($urandom));
      press();
      wait_done("rand_done");
    end

`ifdef LBC_WATCHDOG_EN
    // Graph 1 never answers
    sweep_en = 1'b1; resp_delay = 5; drop_graph = 1;
    push_code(2'b01);
    press();
    wait_done("wd_done");
    chk("wd_timeout_err", 32'(timeout_err), 1);
    chk("wd_total", 32'(total_cnt), 1);
    chk("wd_graph", 32'(graph), 1);
    drop_graph = -1;
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
